// File: rtl/fractal_sync_nc_node.sv
// N-child fractal synchronization node: gathers child barrier requests into a small
// barrier table, wakes children on local completion, and relays higher-level barriers upward.
module fractal_sync_nc_node #(
   parameter int unsigned N_CHILDREN = 2,
   parameter int unsigned N_ENTRIES  = 4,
   parameter int unsigned LVL_WIDTH  = 8,
   parameter int unsigned LVL_OFFSET = 1,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ID_OFFSET  = 1
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic [N_CHILDREN-1:0]                            c_sync_i,
   input  logic [N_CHILDREN-1:0][LVL_WIDTH-1:0]             c_level_i,
   input  logic [N_CHILDREN-1:0][ID_WIDTH-1:0]              c_id_i,
   output logic [N_CHILDREN-1:0]                            c_wake_o,
   output logic [N_CHILDREN-1:0][LVL_WIDTH-1:0]             c_level_o,
   output logic [N_CHILDREN-1:0][ID_WIDTH+ID_OFFSET-1:0]    c_id_o,
   output logic [N_CHILDREN-1:0]                            c_error_o,
   output logic                                             p_sync_o,
   output logic [LVL_WIDTH-LVL_OFFSET-1:0]                  p_level_o,
   output logic [ID_WIDTH+ID_OFFSET-1:0]                    p_id_o,
   input  logic                                             p_wake_i,
   input  logic [LVL_WIDTH-LVL_OFFSET-1:0]                  p_level_i,
   input  logic [ID_WIDTH+ID_OFFSET-1:0]                    p_id_i,
   input  logic                                             p_error_i
);

   localparam int IDW = ID_WIDTH + ID_OFFSET;
   localparam int PLW = LVL_WIDTH - LVL_OFFSET;

   typedef enum logic [1:0] {FREE = 2'd0, GATHER = 2'd1, UP_PEND = 2'd2, WAIT_P = 2'd3} state_t;

   typedef struct packed {
      state_t                state;
      logic [LVL_WIDTH-1:0]  level;
      logic [ID_WIDTH-1:0]   id;
      logic [N_CHILDREN-1:0] arrived;
   } entry_t;

   entry_t [N_ENTRIES-1:0] table_reg, table_next;

   logic [N_CHILDREN-1:0]                req_error;
   logic [N_CHILDREN-1:0][LVL_WIDTH-1:0] c_level_next;
   logic [N_CHILDREN-1:0][IDW-1:0]       c_id_next;
   logic                                 p_sync_next;
   logic [PLW-1:0]                       p_level_next;
   logic [IDW-1:0]                       p_id_next;

   logic                 p_hit;
   int                   p_idx;
   logic                 bcast, bcast_wake, bcast_error;
   logic [LVL_WIDTH-1:0] bcast_level;
   logic [ID_WIDTH-1:0]  bcast_id;
   logic                 found, legal, done;
   int                   slot;

   // Parent level is not needed for matching; only the low id bits are.
   logic unused_inputs;
   assign unused_inputs = ^{p_level_i, p_id_i};

   always_comb begin
      table_next   = table_reg;
      req_error    = '0;
      p_hit        = 1'b0;
      p_idx        = 0;
      bcast        = 1'b0;
      bcast_wake   = 1'b0;
      bcast_error  = 1'b0;
      bcast_level  = '0;
      bcast_id     = '0;
      p_sync_next  = 1'b0;
      p_level_next = '0;
      p_id_next    = '0;
      found        = 1'b0;
      legal        = 1'b0;
      done         = 1'b0;
      slot         = 0;

      // Parent responses only match barriers already waiting before this edge.
      if (p_wake_i || p_error_i) begin
         for (int e = 0; e < N_ENTRIES; e++) begin
            if (!p_hit && table_reg[e].state == WAIT_P &&
                table_reg[e].id == p_id_i[ID_WIDTH-1:0]) begin
               p_hit = 1'b1;
               p_idx = e;
            end
         end
      end

      // Children in ascending order, so earlier allocations this cycle are visible to later ones.
      for (int c = 0; c < N_CHILDREN; c++) begin
         if (c_sync_i[c]) begin
            legal = (c_level_i[c] != '0) &&
                    ((c_level_i[c] & (c_level_i[c] - 1'b1)) == '0) &&
                    (c_level_i[c][0] || (c_level_i[c][LVL_WIDTH-1:LVL_OFFSET] != '0));
            found = 1'b0;
            slot  = 0;
            for (int e = 0; e < N_ENTRIES; e++) begin
               if (!found && table_next[e].state != FREE && table_next[e].id == c_id_i[c]) begin
                  found = 1'b1;
                  slot  = e;
               end
            end
            if (!legal) begin
               req_error[c] = 1'b1;
            end else if (found) begin
               if (table_next[slot].level != c_level_i[c] || table_next[slot].arrived[c])
                  req_error[c] = 1'b1;
               else
                  table_next[slot].arrived[c] = 1'b1;
            end else begin
               for (int e = 0; e < N_ENTRIES; e++) begin
                  if (!found && table_next[e].state == FREE) begin
                     found = 1'b1;
                     slot  = e;
                  end
               end
               if (!found) begin
                  req_error[c] = 1'b1;
               end else begin
                  table_next[slot].state      = GATHER;
                  table_next[slot].level      = c_level_i[c];
                  table_next[slot].id         = c_id_i[c];
                  table_next[slot].arrived    = '0;
                  table_next[slot].arrived[c] = 1'b1;
               end
            end
         end
      end

      for (int e = 0; e < N_ENTRIES; e++) begin
         if (table_next[e].state == GATHER && (&table_next[e].arrived) && !table_next[e].level[0])
            table_next[e].state = UP_PEND;
      end

      for (int e = 0; e < N_ENTRIES; e++) begin
         if (!p_sync_next && table_next[e].state == UP_PEND) begin
            table_next[e].state = WAIT_P;
            p_sync_next  = 1'b1;
            p_level_next = table_next[e].level[LVL_WIDTH-1:LVL_OFFSET];
            p_id_next    = IDW'(table_next[e].id);
         end
      end

      // A matched parent response owns the child lanes; a finished local barrier then waits a cycle.
      if (p_hit) begin
         bcast       = 1'b1;
         bcast_wake  = !p_error_i;
         bcast_error = p_error_i;
         bcast_level = table_reg[p_idx].level;
         bcast_id    = table_reg[p_idx].id;
         table_next[p_idx] = '0;
      end else begin
         bcast_error = p_wake_i || p_error_i;
         for (int e = 0; e < N_ENTRIES; e++) begin
            if (!done && table_next[e].state == GATHER && (&table_next[e].arrived) &&
                table_next[e].level[0]) begin
               done        = 1'b1;
               bcast       = 1'b1;
               bcast_wake  = 1'b1;
               bcast_level = table_next[e].level;
               bcast_id    = table_next[e].id;
               table_next[e] = '0;
            end
         end
      end
   end

   for (genvar gi = 0; gi < N_CHILDREN; gi++) begin : g_lane
      assign c_level_next[gi] = bcast ? bcast_level :
                                (req_error[gi] ? c_level_i[gi] : '0);
      assign c_id_next[gi]    = bcast ? IDW'(bcast_id) :
                                (req_error[gi] ? IDW'(c_id_i[gi]) : '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         table_reg <= '0;
         c_wake_o  <= '0;
         c_error_o <= '0;
         c_level_o <= '0;
         c_id_o    <= '0;
         p_sync_o  <= 1'b0;
         p_level_o <= '0;
         p_id_o    <= '0;
      end else begin
         table_reg <= table_next;
         c_wake_o  <= {N_CHILDREN{bcast_wake}};
         c_error_o <= req_error | {N_CHILDREN{bcast_error}};
         c_level_o <= c_level_next;
         c_id_o    <= c_id_next;
         p_sync_o  <= p_sync_next;
         p_level_o <= p_level_next;
         p_id_o    <= p_id_next;
      end
   end

endmodule

// File: tb/tb_fractal_sync_nc_node.sv
// Bench for fractal_sync_nc_node (4 children, 2 entries): barrier-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fractal_sync_nc_node;

   localparam int NC = 4;
   localparam int NE = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NC-1:0]       c_sync;
   logic [NC-1:0][7:0]  c_level;
   logic [NC-1:0][3:0]  c_id;
   logic [NC-1:0]       c_wake;
   logic [NC-1:0][7:0]  c_level_out;
   logic [NC-1:0][4:0]  c_id_out;
   logic [NC-1:0]       c_error;
   logic                p_sync;
   logic [6:0]          p_level;
   logic [4:0]          p_id;
   logic                p_wake;
   logic [6:0]          p_level_in;
   logic [4:0]          p_id_in;
   logic                p_error;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fractal_sync_nc_node #(
      .N_CHILDREN(NC), .N_ENTRIES(NE), .LVL_WIDTH(8), .LVL_OFFSET(1), .ID_WIDTH(4), .ID_OFFSET(1)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .c_sync_i(c_sync), .c_level_i(c_level), .c_id_i(c_id),
      .c_wake_o(c_wake), .c_level_o(c_level_out), .c_id_o(c_id_out), .c_error_o(c_error),
      .p_sync_o(p_sync), .p_level_o(p_level), .p_id_o(p_id),
      .p_wake_i(p_wake), .p_level_i(p_level_in), .p_id_i(p_id_in), .p_error_i(p_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a set of open barriers, each gathering, queued for the parent, or waiting on it.
   logic       m_used  [NE];
   logic [7:0] m_lvl   [NE];
   logic [3:0] m_id    [NE];
   logic [3:0] m_mask  [NE];
   int         m_stage [NE];   // 0 gathering, 1 ready to go up, 2 waiting for parent

   logic [3:0] x_wake, x_err;
   logic       x_psync;
   logic [6:0] x_plvl;
   logic [4:0] x_pid;
   logic [7:0] x_lvl;
   logic [3:0] x_id;

   task automatic clear_expect();
      x_wake = '0; x_err = '0; x_psync = 1'b0; x_plvl = '0; x_pid = '0; x_lvl = '0; x_id = '0;
   endtask

   task automatic model_reset();
      for (int e = 0; e < NE; e++) begin
         m_used[e] = 1'b0; m_lvl[e] = '0; m_id[e] = '0; m_mask[e] = '0; m_stage[e] = 0;
      end
      clear_expect();
   endtask

   task automatic model_step();
      int hit, slot, loc;
      logic [7:0] lv;
      clear_expect();
      hit = -1;
      if (p_wake || p_error)
         for (int e = 0; e < NE; e++)
            if (hit < 0 && m_used[e] && m_stage[e] == 2 && m_id[e] == p_id_in[3:0]) hit = e;
      for (int c = 0; c < NC; c++) begin
         if (c_sync[c]) begin
            lv = c_level[c];
            slot = -1;
            for (int e = 0; e < NE; e++)
               if (slot < 0 && m_used[e] && m_id[e] == c_id[c]) slot = e;
            if ($countones(lv) != 1 || (!lv[0] && (lv >> 1) == 0)) begin
               x_err[c] = 1'b1;
            end else if (slot >= 0) begin
               if (m_lvl[slot] != lv || m_mask[slot][c]) x_err[c] = 1'b1;
               else m_mask[slot][c] = 1'b1;
            end else begin
               for (int e = 0; e < NE; e++)
                  if (slot < 0 && !m_used[e]) slot = e;
               if (slot < 0) x_err[c] = 1'b1;
               else begin
                  m_used[slot] = 1'b1; m_lvl[slot] = lv; m_id[slot] = c_id[c];
                  m_mask[slot] = 4'(1 << c); m_stage[slot] = 0;
               end
            end
         end
      end
      for (int e = 0; e < NE; e++)
         if (m_used[e] && m_stage[e] == 0 && m_mask[e] == 4'hF && !m_lvl[e][0]) m_stage[e] = 1;
      for (int e = 0; e < NE; e++)
         if (!x_psync && m_used[e] && m_stage[e] == 1) begin
            m_stage[e] = 2; x_psync = 1'b1; x_plvl = m_lvl[e][7:1]; x_pid = {1'b0, m_id[e]};
         end
      if (hit >= 0) begin
         if (p_error) x_err = 4'hF; else x_wake = 4'hF;
         x_lvl = m_lvl[hit]; x_id = m_id[hit]; m_used[hit] = 1'b0;
      end else begin
         if (p_wake || p_error) x_err = 4'hF;
         loc = -1;
         for (int e = 0; e < NE; e++)
            if (loc < 0 && m_used[e] && m_stage[e] == 0 && m_mask[e] == 4'hF && m_lvl[e][0]) loc = e;
         if (loc >= 0) begin
            x_wake = 4'hF; x_lvl = m_lvl[loc]; x_id = m_id[loc]; m_used[loc] = 1'b0;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
      #1;
      check("m_wake",   32'(c_wake),  32'(x_wake));
      check("m_error",  32'(c_error), 32'(x_err));
      check("m_psync",  32'(p_sync),  32'(x_psync));
      check("m_plevel", 32'(p_level), 32'(x_plvl));
      check("m_pid",    32'(p_id),    32'(x_pid));
      if (x_wake != 0)
         for (int c = 0; c < NC; c++) begin
            check("m_clevel", 32'(c_level_out[c]), 32'(x_lvl));
            check("m_cid",    32'(c_id_out[c]),    32'({1'b0, x_id}));
         end
   end

   task automatic next_cycle();
      @(negedge clk);
      c_sync = '0; c_level = '0; c_id = '0;
      p_wake = 1'b0; p_error = 1'b0; p_id_in = '0; p_level_in = '0;
   endtask

   task automatic req(input int c, input logic [7:0] lv, input logic [3:0] id);
      c_sync[c] = 1'b1; c_level[c] = lv; c_id[c] = id;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      c_sync = '0; c_level = '0; c_id = '0;
      p_wake = 1'b0; p_error = 1'b0; p_id_in = '0; p_level_in = '0;
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_wake", 32'(c_wake), 0);
      check("rst_error", 32'(c_error), 0);
      check("rst_psync", 32'(p_sync), 0);

      // Local barrier, arrivals spread over four cycles
      for (int c = 0; c < NC; c++) begin
         next_cycle(); req(c, 8'h01, 4'd3); settle();
         if (c < NC - 1) check("t1_early_wake", 32'(c_wake), 0);
      end
      check("t1_wake", 32'(c_wake), 32'h0F);
      check("t1_id", 32'(c_id_out[0]), 32'd3);
      check("t1_level", 32'(c_level_out[3]), 32'h01);
      next_cycle(); settle();
      check("t1_wake_once", 32'(c_wake), 0);

      // Upward barrier and parent wake
      next_cycle(); for (int c = 0; c < NC; c++) req(c, 8'h02, 4'd2); settle();
      check("t2_psync", 32'(p_sync), 1);
      check("t2_plevel", 32'(p_level), 32'h01);
      check("t2_pid", 32'(p_id), 32'h02);
      next_cycle(); settle();
      check("t2_psync_once", 32'(p_sync), 0);
      next_cycle(); settle();
      next_cycle(); p_wake = 1'b1; p_id_in = 5'd2; settle();
      check("t2_wake", 32'(c_wake), 32'h0F);
      check("t2_level", 32'(c_level_out[1]), 32'h02);
      check("t2_id", 32'(c_id_out[2]), 32'd2);

      // Duplicate arrival
      next_cycle(); req(1, 8'h01, 4'd5); settle();
      next_cycle(); req(1, 8'h01, 4'd5); settle();
      check("t3_dup_error", 32'(c_error), 32'b0010);
      next_cycle(); req(0, 8'h01, 4'd5); req(2, 8'h01, 4'd5); req(3, 8'h01, 4'd5); settle();
      check("t3_wake", 32'(c_wake), 32'h0F);
      check("t3_error_clear", 32'(c_error), 0);

      // Illegal levels: two bits set, and zero
      next_cycle(); req(0, 8'h03, 4'd0); req(2, 8'h00, 4'd1); settle();
      check("t4_illegal", 32'(c_error), 32'b0101);

      // Table overflow with two entries
      next_cycle(); req(0, 8'h01, 4'd1); req(1, 8'h01, 4'd2); req(2, 8'h01, 4'd3); settle();
      check("t5_overflow", 32'(c_error), 32'b0100);
      next_cycle(); req(1, 8'h01, 4'd1); req(2, 8'h01, 4'd1); req(3, 8'h01, 4'd1); settle();
      check("t5_wake_id1", 32'(c_id_out[0]), 32'd1);
      next_cycle(); req(0, 8'h01, 4'd2); req(2, 8'h01, 4'd2); req(3, 8'h01, 4'd2); settle();
      check("t5_wake_id2", 32'(c_id_out[0]), 32'd2);
      next_cycle(); req(3, 8'h01, 4'd3); settle();
      check("t5_realloc", 32'(c_error), 0);
      next_cycle(); req(0, 8'h01, 4'd3); req(1, 8'h01, 4'd3); req(2, 8'h01, 4'd3); settle();
      check("t5_wake_id3", 32'(c_id_out[3]), 32'd3);

      // Two entries going up in the same cycle
      next_cycle(); req(0, 8'h02, 4'd6); req(1, 8'h02, 4'd6); req(2, 8'h02, 4'd7); req(3, 8'h02, 4'd7); settle();
      next_cycle(); req(0, 8'h02, 4'd7); req(1, 8'h02, 4'd7); req(2, 8'h02, 4'd6); req(3, 8'h02, 4'd6); settle();
      check("t6_first_pid", 32'(p_id), 32'd6);
      next_cycle(); settle();
      check("t6_second_psync", 32'(p_sync), 1);
      check("t6_second_pid", 32'(p_id), 32'd7);
      next_cycle(); p_wake = 1'b1; p_id_in = 5'd7; settle();
      check("t6_wake_id7", 32'(c_id_out[1]), 32'd7);
      next_cycle(); p_wake = 1'b1; p_error = 1'b1; p_id_in = 5'd6; settle();
      check("t6_err_wins", 32'(c_error), 32'h0F);
      check("t6_no_wake", 32'(c_wake), 0);

      // Parent response and local completion in the same cycle
      next_cycle(); for (int c = 0; c < NC; c++) req(c, 8'h02, 4'd4); settle();
      next_cycle(); req(0, 8'h01, 4'd9); req(1, 8'h01, 4'd9); req(2, 8'h01, 4'd9); settle();
      next_cycle(); req(3, 8'h01, 4'd9); p_wake = 1'b1; p_id_in = 5'd4; settle();
      check("t7_parent_first", 32'(c_id_out[0]), 32'd4);
      check("t7_parent_level", 32'(c_level_out[0]), 32'h02);
      next_cycle(); settle();
      check("t7_local_wake", 32'(c_wake), 32'h0F);
      check("t7_local_id", 32'(c_id_out[0]), 32'd9);

      // Reset while waiting on the parent
      next_cycle(); for (int c = 0; c < NC; c++) req(c, 8'h02, 4'd8); settle();
      check("t8_psync", 32'(p_sync), 1);
      next_cycle(); rst = 1'b1; settle();
      check("t8_rst_out", 32'(p_sync), 0);
      next_cycle(); rst = 1'b0; settle();
      next_cycle(); p_wake = 1'b1; p_id_in = 5'd8; settle();
      check("t8_no_wake", 32'(c_wake), 0);
      check("t8_unmatched", 32'(c_error), 32'h0F);

      repeat (3) begin next_cycle(); settle(); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fractal_sync_nc_node.md
Name: fractal_sync_nc_node

Overview:
- N-child fractal synchronization node. Aggregates barrier requests from N_CHILDREN child master ports, each with level/id semantics, into a multi-entry barrier table.
- Local barriers (level bit 0 set) wake all children once complete.
- Higher-level barriers send one merged request to the parent and relay the parent's wake or error back down.
- Successor to the fixed two-child node: parametrised fan-in, concurrent barriers, error reporting.

Parameters:
- N_CHILDREN, 2, number of child ports (2..16).
- N_ENTRIES, 4, barrier table depth (concurrent in-flight barriers).
- LVL_WIDTH, 8, child request level width; one-hot level encoding.
- LVL_OFFSET, 1, level bits removed per upward hop.
- ID_WIDTH, 4, child request barrier id width.
- ID_OFFSET, 1, zero bits prepended to the id on the upward hop.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- c_sync_i  in  [N_CHILDREN]  child sync request pulse
- c_level_i  in  [N_CHILDREN][LVL_WIDTH]  child request level
- c_id_i  in  [N_CHILDREN][ID_WIDTH]  child request id
- c_wake_o  out  [N_CHILDREN]  wake pulse per child
- c_level_o  out  [N_CHILDREN][LVL_WIDTH]  level of the woken/errored barrier
- c_id_o  out  [N_CHILDREN][ID_WIDTH+ID_OFFSET]  id of the barrier, zero-extended
- c_error_o  out  [N_CHILDREN]  error pulse per child
- p_sync_o  out  1  upward sync pulse
- p_level_o  out  LVL_WIDTH-LVL_OFFSET  c_level >> LVL_OFFSET
- p_id_o  out  ID_WIDTH+ID_OFFSET  {ID_OFFSET'0, id}
- p_wake_i  in  1  parent wake pulse
- p_level_i  in  LVL_WIDTH-LVL_OFFSET  parent response level (ignored for matching)
- p_id_i  in  ID_WIDTH+ID_OFFSET  parent response id; low ID_WIDTH bits are used for matching
- p_error_i  in  1  parent error pulse

Behaviour:
- Reset: all entries FREE; every output 0. Reset mid-operation drops all barriers; no wake is issued afterwards.
- Entry fields: state, level, id, arrived bitmap [N_CHILDREN].
- Entry states: FREE, GATHER, UP_PEND, WAIT_P.

Child requests:
- c_sync_i is sampled each edge; all children are processed in the same cycle.
- Match rule: a request matches a non-FREE entry with equal id.
  - Equal level, arrived bit clear: set the bit.
  - Arrived bit already set: c_error_o pulse for that child, next cycle (duplicate).
  - Level differs: c_error_o pulse for that child, next cycle (mismatch).
  - Level not one-hot, or upward level (c_level >> LVL_OFFSET) zero while bit 0 clear: c_error_o pulse next cycle (illegal level); no allocation.
- No match: allocate the lowest FREE entry -> GATHER.
  - Several unmatched requests in one cycle are handled in ascending child index.
  - Requests with identical id/level in that cycle share one entry.
  - No FREE entry left: c_error_o pulse for the overflow child; request dropped.

Completion (arrived == all ones):
- level[0]=1: the entry frees.
  - c_wake_o = all ones for exactly one cycle, the cycle after the last arrival was sampled (1-cycle latency).
  - c_level_o/c_id_o carry the entry's level/id.
- level[0]=0: entry -> UP_PEND.

Upward arbitration:
- One p_sync_o pulse per cycle, granted to the lowest-index UP_PEND entry; that entry -> WAIT_P.
- Best case p_sync_o appears 1 cycle after the last arrival.
- p_level_o/p_id_o are valid only while p_sync_o=1, else 0.

Parent response:
- p_wake_i or p_error_i matches the WAIT_P entry whose id == p_id_i[ID_WIDTH-1:0].
- On match: next cycle pulse c_wake_o (or c_error_o) on all children, with the entry's level/id; the entry frees.
- Both p_wake_i and p_error_i high: error wins.
- No matching WAIT_P entry: the response is ignored and an error pulse goes on all c_error_o.

Timing and ordering:
- Same-cycle simultaneous events are allowed: local completion, parent response to a different entry, and new allocation.
- A freed entry is reusable from the cycle after it frees; it cannot be reallocated in the cycle it frees.
- If two entries drive child outputs in one cycle, the parent response has priority. The local completion waits one cycle, its entry stays valid until then, and there is no loss.
- All outputs are registered.

Test Plan:
- N_CHILDREN=4, all children sync id=3 level=8'h01 in different cycles (last at cycle t) -> c_wake_o=4'hF at t+1 only; c_id_o=3; entry FREE afterwards.
- All 4 children sync id=2 level=8'h02 -> p_sync_o at t+1 with p_level_o=7'h01, p_id_o=5'h02. p_wake_i with p_id_i=2 at cycle u -> c_wake_o=4'hF at u+1, c_level_o=8'h02.
- Child 1 syncs id=5 twice before completion -> second request gives c_error_o=4'b0010 next cycle; the barrier still completes normally.
- N_ENTRIES=2: children 0,1,2 sync distinct ids 1,2,3 in one cycle -> entries hold ids 1,2; c_error_o=4'b0100 next cycle.
- Two entries reach UP_PEND in the same cycle -> p_sync_o on two consecutive cycles, lower entry index first.
- Reset asserted while an entry is in WAIT_P, then p_wake_i arrives after release -> no c_wake_o; c_error_o=all ones (unmatched response).
